// File: rtl/proc_ctrl_pkg.sv
// Shared types for the multi-cycle phase controller: phase encoding, strobe
// bundle and the phase-to-strobe decode used for the registered outputs.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_INIT   = 3'd0,
        PH_FETCH  = 3'd1,
        PH_DECODE = 3'd2,
        PH_EXEC   = 3'd3,
        PH_MEM    = 3'd4,
        PH_WB     = 3'd5,
        PH_HALT   = 3'd6
    } phase_e;

    localparam int DEFAULT_INIT_CYCLES = 4;

    typedef struct packed {
        logic imem;
        logic regfile;
        logic rf_wb;
        logic proc;
        logic dmem;
        logic halted;
    } strobes_t;

    function automatic strobes_t decode_phase(input phase_e ph);
        strobes_t s;
        s = strobes_t'(6'b000000);
        case (ph)
            PH_FETCH:  s.imem    = 1'b1;
            PH_DECODE: s.regfile = 1'b1;
            PH_EXEC:   s.proc    = 1'b1;
            PH_MEM:    s.dmem    = 1'b1;
            PH_WB: begin
                s.regfile = 1'b1;
                s.rf_wb   = 1'b1;
            end
            PH_HALT:   s.halted  = 1'b1;
            default:   s = strobes_t'(6'b000000);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and hold at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over increment; the all-ones value is sticky.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {W{1'b0}};
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cycle_phase_controller.sv
// Five-phase instruction sequencer producing per-phase enables from one clock,
// with EXEC stall handling, stall watchdog, halt and retirement counting.
module cycle_phase_controller
    import proc_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES   = DEFAULT_INIT_CYCLES,
    parameter int STALL_TIMEOUT = 1024,
    parameter int ICNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              halt_req,
    output logic              imem_en,
    output logic              regfile_en,
    output logic              rf_wb,
    output logic              proc_en,
    output logic              dmem_en,
    output logic [2:0]        phase,
    output logic              halted,
    output logic [ICNT_W-1:0] instr_count,
    output logic [15:0]       stall_count,
    output logic              stall_timeout
);

    localparam logic [7:0]  INIT_LAST   = (INIT_CYCLES == 0) ? 8'd0 : 8'(INIT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(STALL_TIMEOUT);

    phase_e            state_q, state_d;
    logic [7:0]        init_cnt_q, init_cnt_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              timeout_q, timeout_d;
    logic              halt_pending_q, halt_pending_d;
    strobes_t          strobes_q, strobes_d;

    logic              run_clr, run_inc, stall_inc;
    logic [15:0]       run_len;
    logic [15:0]       stall_cnt;

    sat_counter #(.W(16)) u_run_len (
        .clock (clock),
        .reset (reset),
        .clr   (run_clr),
        .en    (run_inc),
        .count (run_len)
    );

    sat_counter #(.W(16)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    // Next-state, counter control and strobe decode of the next state.
    always_comb begin
        state_d        = state_q;
        init_cnt_d     = 8'd0;
        icnt_d         = icnt_q;
        timeout_d      = timeout_q;
        halt_pending_d = halt_pending_q;
        run_clr        = 1'b0;
        run_inc        = 1'b0;
        stall_inc      = 1'b0;

        if (state_q != PH_INIT) begin
            halt_pending_d = halt_pending_q | halt_req;
        end else begin
            halt_pending_d = halt_pending_q;
        end

        case (state_q)
            PH_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = PH_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q + 8'd1;
                end
            end
            PH_FETCH:  state_d = PH_DECODE;
            PH_DECODE: state_d = PH_EXEC;
            PH_EXEC: begin
                // A stall that has already run the full budget forces the advance.
                if (stall && (run_len != TIMEOUT_LIM)) begin
                    run_inc   = 1'b1;
                    stall_inc = 1'b1;
                end else begin
                    state_d = PH_MEM;
                    run_clr = 1'b1;
                    if (stall) begin
                        timeout_d = 1'b1;
                    end else begin
                        timeout_d = timeout_q;
                    end
                end
            end
            PH_MEM: state_d = PH_WB;
            PH_WB: begin
                icnt_d         = icnt_q + ICNT_W'(1);
                halt_pending_d = 1'b0;
                if (halt_pending_q || halt_req) begin
                    state_d = PH_HALT;
                end else begin
                    state_d = PH_FETCH;
                end
            end
            PH_HALT: state_d = PH_HALT;
            default: state_d = PH_INIT;
        endcase

        strobes_d = decode_phase(state_d);
    end

    // State, counters and output strobe registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= PH_INIT;
            init_cnt_q     <= 8'd0;
            icnt_q         <= {ICNT_W{1'b0}};
            timeout_q      <= 1'b0;
            halt_pending_q <= 1'b0;
            strobes_q      <= strobes_t'(6'b000000);
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            icnt_q         <= icnt_d;
            timeout_q      <= timeout_d;
            halt_pending_q <= halt_pending_d;
            strobes_q      <= strobes_d;
        end
    end

    assign imem_en       = strobes_q.imem;
    assign regfile_en    = strobes_q.regfile;
    assign rf_wb         = strobes_q.rf_wb;
    assign proc_en       = strobes_q.proc;
    assign dmem_en       = strobes_q.dmem;
    assign halted        = strobes_q.halted;
    assign phase         = state_q;
    assign instr_count   = icnt_q;
    assign stall_count   = stall_cnt;
    assign stall_timeout = timeout_q;

endmodule
